// File: rtl/video_snapshot.sv
`default_nettype none
// -----------------------------------------------------------------------------
// video_snapshot : single-shot 12-bit video capture, read back as a byte stream
// Optional trigger gating when SNAPSHOT_TRIG_EN is defined.   Rev 1.0
// -----------------------------------------------------------------------------
module video_snapshot #(
    parameter int DEPTH = 127
) (
    input  logic        sys_clk,
    input  logic        n_rst,
    input  logic [7:0]  in_data,
    input  logic        in_ena,
    input  logic [11:0] video,
    input  logic        video_valid,
    input  logic        trig,
    output logic        have_msg,
    output logic [7:0]  len,
    input  logic        enc_rdreq,
    output logic [7:0]  out_data,
    output logic        busy
);

    localparam logic [6:0] DEPTH_W = 7'(DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TRIG = 3'd1,
        CAPTURE   = 3'd2,
        READY     = 3'd3,
        SEND      = 3'd4
    } state_t;

    state_t      state;
    logic [6:0]  n_samp;
    logic [6:0]  wptr;
    logic [7:0]  bptr;
    logic [11:0] head;
    logic [7:0]  low_byte;
    logic [11:0] mem [0:DEPTH-1];
    logic [11:0] rdata;

    logic        armable;
    logic        arm_go;
    logic        arm_kill;
    logic [6:0]  arm_n;
    logic        wr_en;
    logic        last_wr;
    logic        rd_go;
    logic        last_rd;
    logic [6:0]  raddr_inc;
    logic [6:0]  raddr;
    logic [11:0] first_sample;

`ifdef SNAPSHOT_TRIG_EN
    logic trig_d;
    logic trig_rise;

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            trig_d <= 1'b0;
        end else begin
            trig_d <= trig;
        end
    end

    assign trig_rise = trig && !trig_d;
    localparam state_t ARM_STATE = WAIT_TRIG;
`else
    logic unused_trig;
    assign unused_trig = trig;
    localparam state_t ARM_STATE = CAPTURE;
`endif

    assign armable   = (state == IDLE) || (state == WAIT_TRIG) || (state == CAPTURE);
    assign arm_go    = in_ena && armable && (in_data != 8'd0);
    assign arm_kill  = in_ena && armable && (in_data == 8'd0);
    assign arm_n     = (in_data > {1'b0, DEPTH_W}) ? DEPTH_W : in_data[6:0];

    // A command in the same cycle as a sample wins; the sample is dropped.
    assign wr_en     = (state == CAPTURE) && video_valid && !in_ena;
    assign last_wr   = wr_en && (wptr == (n_samp - 7'd1));
    assign rd_go     = enc_rdreq && ((state == READY) || (state == SEND));
    assign last_rd   = rd_go && (bptr == ({n_samp, 1'b0} - 8'd1));

    // Prefetch the sample after the one on display so its high byte is ready
    // the cycle after the current low byte is consumed.
    assign raddr_inc = bptr[7:1] + 7'd1;
    assign raddr     = (raddr_inc >= DEPTH_W) ? 7'd0 : raddr_inc;

    // Sample 0 is held outside the RAM so byte 0 is valid as have_msg rises.
    assign first_sample = (wptr == 7'd0) ? video : head;

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wptr] <= video;
        end
        rdata <= mem[raddr];
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            n_samp   <= 7'd0;
            wptr     <= 7'd0;
            bptr     <= 8'd0;
            head     <= 12'd0;
            low_byte <= 8'd0;
            have_msg <= 1'b0;
            len      <= 8'd0;
            out_data <= 8'd0;
            busy     <= 1'b0;
        end else if (arm_kill) begin
            state <= IDLE;
            wptr  <= 7'd0;
            busy  <= 1'b0;
        end else if (arm_go) begin
            state  <= ARM_STATE;
            n_samp <= arm_n;
            wptr   <= 7'd0;
            busy   <= 1'b1;
        end else begin
            case (state)
`ifdef SNAPSHOT_TRIG_EN
                WAIT_TRIG: begin
                    if (trig_rise) begin
                        state <= CAPTURE;
                    end
                end
`endif
                CAPTURE: begin
                    if (wr_en) begin
                        wptr <= wptr + 7'd1;
                        if (wptr == 7'd0) begin
                            head <= video;
                        end
                        if (last_wr) begin
                            state    <= READY;
                            have_msg <= 1'b1;
                            len      <= {n_samp, 1'b0};
                            bptr     <= 8'd0;
                            out_data <= {4'b0000, first_sample[11:8]};
                            low_byte <= first_sample[7:0];
                        end
                    end
                end
                READY, SEND: begin
                    if (rd_go) begin
                        if (last_rd) begin
                            state    <= IDLE;
                            have_msg <= 1'b0;
                            len      <= 8'd0;
                            out_data <= 8'd0;
                            busy     <= 1'b0;
                            bptr     <= 8'd0;
                        end else begin
                            state <= SEND;
                            bptr  <= bptr + 8'd1;
                            if (bptr[0]) begin
                                out_data <= {4'b0000, rdata[11:8]};
                                low_byte <= rdata[7:0];
                            end else begin
                                out_data <= low_byte;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_snapshot.sv
`default_nettype none
// Bench for video_snapshot: queue-based behavioural model plus directed vectors.
module tb_video_snapshot;

    localparam int DEPTH = 127;
`ifdef SNAPSHOT_TRIG_EN
    localparam bit TRIG_EN = 1'b1;
`else
    localparam bit TRIG_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ena = 1'b0;
    logic [11:0] video = 12'd0;
    logic        video_valid = 1'b0;
    logic        trig = 1'b0;
    logic        enc_rdreq = 1'b0;
    logic        have_msg;
    logic [7:0]  len;
    logic [7:0]  out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [7:0] t1_bytes [6] = '{8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF};
    logic [7:0] t3_bytes [4] = '{8'h05, 8'h55, 8'h06, 8'h66};

    video_snapshot #(.DEPTH(DEPTH)) dut (
        .sys_clk     (sys_clk),
        .n_rst       (n_rst),
        .in_data     (in_data),
        .in_ena      (in_ena),
        .video       (video),
        .video_valid (video_valid),
        .trig        (trig),
        .have_msg    (have_msg),
        .len         (len),
        .enc_rdreq   (enc_rdreq),
        .out_data    (out_data),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 waiting for trigger, 2 capturing, 3 message pending.
    int          m_mode = 0;
    int          m_n = 0;
    int          m_ptr = 0;
    logic        m_trig_prev = 1'b0;
    logic [11:0] m_samp [$];
    logic [7:0]  m_bytes [$];

    always @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            m_mode = 0;
            m_n = 0;
            m_ptr = 0;
            m_trig_prev = 1'b0;
            m_samp.delete();
            m_bytes.delete();
        end else begin
            if (in_ena && m_mode != 3) begin
                if (in_data == 8'd0) begin
                    m_mode = 0;
                end else begin
                    m_n = (int'(in_data) > DEPTH) ? DEPTH : int'(in_data);
                    m_samp.delete();
                    m_mode = TRIG_EN ? 1 : 2;
                end
            end else if (m_mode == 1) begin
                if (trig && !m_trig_prev) m_mode = 2;
            end else if (m_mode == 2 && video_valid) begin
                m_samp.push_back(video);
                if (m_samp.size() == m_n) begin
                    m_bytes.delete();
                    foreach (m_samp[i]) begin
                        m_bytes.push_back({4'h0, m_samp[i][11:8]});
                        m_bytes.push_back(m_samp[i][7:0]);
                    end
                    m_ptr = 0;
                    m_mode = 3;
                end
            end else if (m_mode == 3 && enc_rdreq) begin
                m_ptr++;
                if (m_ptr == m_bytes.size()) m_mode = 0;
            end
            m_trig_prev = trig;
        end
    end

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            chk("busy", busy, 32'(m_mode != 0));
            chk("have_msg", have_msg, 32'(m_mode == 3));
            chk("len", len, (m_mode == 3) ? 2 * m_n : 0);
            if (m_mode == 3) chk("out_data", out_data, 32'(m_bytes[m_ptr]));
        end
    end

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic arm(input logic [7:0] d);
        in_data = d;
        in_ena = 1'b1;
        cyc();
        in_ena = 1'b0;
        in_data = 8'd0;
    endtask

    task automatic trig_pulse();
        if (TRIG_EN) begin
            trig = 1'b1;
            cyc();
            trig = 1'b0;
        end
    endtask

    task automatic start(input logic [7:0] d);
        arm(d);
        trig_pulse();
    endtask

    task automatic feed(input logic [11:0] v);
        video = v;
        video_valid = 1'b1;
        cyc();
        video_valid = 1'b0;
    endtask

    task automatic rd();
        enc_rdreq = 1'b1;
        cyc();
        enc_rdreq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc();
        cyc();
        chk("rst_have_msg", have_msg, 0);
        chk("rst_len", len, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        n_rst = 1'b1;
        cmp_en = 1'b1;
        cyc();

        // Read strobe with nothing pending is ignored.
        rd();
        chk("idle_rd_have", have_msg, 0);

        // Three samples, single reads with gaps.
        arm(8'h03);
        chk("arm_busy", busy, 1);
        trig_pulse();
        feed(12'hABC);
        cyc();
        feed(12'h123);
        feed(12'hFFF);
        chk("t1_have", have_msg, 1);
        chk("t1_len", len, 6);
        chk("t1_first", out_data, 8'h0A);
        arm(8'h10);
        chk("ready_ignore_len", len, 6);
        chk("ready_ignore_data", out_data, 8'h0A);
        foreach (t1_bytes[i]) begin
            chk("t1_byte", out_data, t1_bytes[i]);
            rd();
            if (i < 5) cyc();
        end
        chk("t1_done_have", have_msg, 0);
        chk("t1_done_busy", busy, 0);
        chk("t1_done_len", len, 0);

        // Oversized request clamps to DEPTH; ramp with back-to-back reads.
        start(8'hFF);
        for (int i = 0; i < 127; i++) begin
            video = 12'(i);
            video_valid = 1'b1;
            cyc();
        end
        video_valid = 1'b0;
        chk("ramp_len", len, 8'hFE);
        enc_rdreq = 1'b1;
        for (int i = 0; i < 254; i++) begin
            chk("ramp_byte", out_data, (i % 2 == 0) ? 0 : i / 2);
            cyc();
        end
        enc_rdreq = 1'b0;
        chk("ramp_done_have", have_msg, 0);

        // Abort-restart; the sample alongside the new command is dropped.
        start(8'h04);
        feed(12'h100);
        feed(12'h200);
        in_data = 8'h02;
        in_ena = 1'b1;
        video = 12'h777;
        video_valid = 1'b1;
        cyc();
        in_ena = 1'b0;
        video_valid = 1'b0;
        trig_pulse();
        feed(12'h555);
        feed(12'h666);
        chk("t3_len", len, 4);
        enc_rdreq = 1'b1;
        foreach (t3_bytes[i]) begin
            chk("t3_byte", out_data, t3_bytes[i]);
            cyc();
        end
        enc_rdreq = 1'b0;
        chk("t3_done_have", have_msg, 0);

        // Zero command aborts to idle; stray samples and reads are ignored.
        start(8'h03);
        feed(12'h321);
        arm(8'h00);
        chk("abort_busy", busy, 0);
        feed(12'h444);
        rd();
        chk("abort_have", have_msg, 0);

        // Single-sample snapshot.
        start(8'h01);
        feed(12'h9A5);
        chk("n1_len", len, 2);
        chk("n1_b0", out_data, 8'h09);
        rd();
        chk("n1_b1", out_data, 8'hA5);
        rd();
        chk("n1_done", have_msg, 0);

        // Reset mid-capture and while a message is pending.
        start(8'h05);
        feed(12'h001);
        feed(12'h002);
        #2 n_rst = 1'b0;
        #1;
        chk("rstcap_busy", busy, 0);
        chk("rstcap_have", have_msg, 0);
        cyc();
        n_rst = 1'b1;
        cyc();
        start(8'h01);
        feed(12'hC3E);
        chk("pre_rst_data", out_data, 8'h0C);
        #2 n_rst = 1'b0;
        #1;
        chk("rstrdy_have", have_msg, 0);
        chk("rstrdy_len", len, 0);
        chk("rstrdy_data", out_data, 0);
        chk("rstrdy_busy", busy, 0);
        cyc();
        n_rst = 1'b1;
        cyc();

`ifdef SNAPSHOT_TRIG_EN
        // Samples before the trigger edge are discarded.
        arm(8'h02);
        feed(12'h111);
        trig = 1'b1;
        cyc();
        feed(12'h222);
        feed(12'h333);
        trig = 1'b0;
        chk("trig_len", len, 4);
        chk("trig_b0", out_data, 8'h02);
        rd();
        chk("trig_b1", out_data, 8'h22);
        rd();
        chk("trig_b2", out_data, 8'h03);
        rd();
        chk("trig_b3", out_data, 8'h33);
        rd();
        chk("trig_done", have_msg, 0);
`endif

        cyc();
        cyc();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
